// File: rtl/vanilla_predecode_queue.sv
`default_nettype none
// ============================================================================
// Module   : vanilla_predecode_queue
// Purpose  : Multi-lane fetch-to-decode instruction buffer. Each enqueued
//            instruction is predecoded at write time. The instruction, its PC
//            and its flags are then held in a circular queue. The head entry
//            is driven straight from storage, so there is no decode logic on
//            the output path.
// Ports    : clk_i, reset_n_i (async, active-low), flush_i
//            v_i/ready_o/num_i/instr_i/pc_i  fetch packet in, lane 0 first
//            v_o/yumi_i/instr_o/pc_o/pd_o    head entry out to decode
//            count_o                         occupied entries
//            pd_o = {illegal,is_fp,is_mem,is_ctrl,read_rs2,read_rs1,
//                    write_rd,is_sys}
// Revision : 1.0  initial release
// ============================================================================
module vanilla_predecode_queue #(
  parameter int els_p      = 4,
  parameter int in_width_p = 2,
  parameter int pc_width_p = 22
) (
  input  logic                            clk_i,
  input  logic                            reset_n_i,
  input  logic                            flush_i,
  input  logic                            v_i,
  output logic                            ready_o,
  input  logic [$clog2(in_width_p+1)-1:0] num_i,
  input  logic [32*in_width_p-1:0]        instr_i,
  input  logic [pc_width_p-1:0]           pc_i,
  output logic                            v_o,
  input  logic                            yumi_i,
  output logic [31:0]                     instr_o,
  output logic [pc_width_p-1:0]           pc_o,
  output logic [7:0]                      pd_o,
  output logic [$clog2(els_p+1)-1:0]      count_o
);

  localparam int c_ptr_w = $clog2(els_p);
  localparam int c_cnt_w = $clog2(els_p + 1);
  localparam int c_num_w = $clog2(in_width_p + 1);

  // Classify one instruction from its opcode and a few fixed fields.
  function automatic logic [7:0] predecode(input logic [31:0] ins);
    logic [6:0] op;
    logic [6:0] f7;
    logic [4:0] rd;
    logic [4:0] rs2;
    logic [2:0] f3;
    logic       is_sys, write_rd, read_rs1, read_rs2;
    logic       is_ctrl, is_mem, is_fp, illegal;
    op  = ins[6:0];
    rd  = ins[11:7];
    f3  = ins[14:12];
    rs2 = ins[24:20];
    f7  = ins[31:25];

    is_sys   = (op == 7'b1110011);
    write_rd = (rd != 5'd0) &&
               ((op inside {7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111,
                            7'b0000011, 7'b0110011, 7'b0010011, 7'b0101111,
                            7'b1110011}) ||
                ((op == 7'b1010011) &&
                 ((f7 == 7'b1010000) || (f7 == 7'b1100000) ||
                  ((f7 == 7'b1110000) && (rs2 == 5'd0)))));
    read_rs1 = (op inside {7'b1100111, 7'b1100011, 7'b0000011, 7'b0100011,
                           7'b0110011, 7'b0010011, 7'b0101111, 7'b0000111,
                           7'b0100111}) ||
               ((op == 7'b1010011) && (f7 inside {7'b1101000, 7'b1111000})) ||
               ((op == 7'b1110011) && (f3 inside {3'b001, 3'b010, 3'b011}));
    read_rs2 = (op inside {7'b1100011, 7'b0100011, 7'b0110011}) ||
               ((op == 7'b0101111) &&
                (f7[6:2] inside {5'b00001, 5'b01000, 5'b00000}));
    is_ctrl  = (op inside {7'b1100011, 7'b1101111, 7'b1100111});
    is_mem   = (op inside {7'b0000011, 7'b0100011, 7'b0000111, 7'b0100111,
                           7'b0101111});
    is_fp    = (op inside {7'b0000111, 7'b0100111, 7'b1010011, 7'b1000011,
                           7'b1000111, 7'b1001011, 7'b1001111});
    // Anything outside the recognised opcode set, except MISC-MEM, is illegal.
    illegal  = !(op inside {7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111,
                            7'b0000011, 7'b0110011, 7'b0010011, 7'b0101111,
                            7'b1110011, 7'b1010011, 7'b1100011, 7'b0100011,
                            7'b0000111, 7'b0100111, 7'b1000011, 7'b1000111,
                            7'b1001011, 7'b1001111, 7'b0001111});
    return {illegal, is_fp, is_mem, is_ctrl, read_rs2, read_rs1, write_rd, is_sys};
  endfunction

  logic [c_ptr_w-1:0]    r_wptr;
  logic [c_ptr_w-1:0]    r_rptr;
  logic [c_cnt_w-1:0]    r_count;
  logic [31:0]           r_instr_mem [els_p];
  logic [pc_width_p-1:0] r_pc_mem    [els_p];
  logic [7:0]            r_pd_mem    [els_p];

  logic                  w_enq;
  logic                  w_deq;
  logic [c_cnt_w-1:0]    w_enq_n;
  logic [c_cnt_w-1:0]    w_free;
  logic                  w_lane_we   [in_width_p];
  logic [c_ptr_w-1:0]    w_lane_addr [in_width_p];
  logic [pc_width_p-1:0] w_lane_pc   [in_width_p];
  logic [7:0]            w_lane_pd   [in_width_p];

  // Ready looks only at the registered count; a same-cycle dequeue does not
  // open room for the incoming packet.
  assign w_free  = c_cnt_w'(els_p) - r_count;
  assign ready_o = (w_free >= c_cnt_w'(in_width_p));
  assign w_enq   = v_i & ready_o & ~flush_i;
  assign w_deq   = yumi_i & v_o & ~flush_i;
  assign w_enq_n = w_enq ? c_cnt_w'(num_i) : '0;

  generate
    for (genvar k = 0; k < in_width_p; k++) begin : g_lane
      localparam logic [c_num_w-1:0] c_lane = c_num_w'(k);
      assign w_lane_we[k]   = w_enq && (c_lane < num_i);
      assign w_lane_addr[k] = r_wptr + c_ptr_w'(k);
      assign w_lane_pc[k]   = pc_i + pc_width_p'(k);
      assign w_lane_pd[k]   = predecode(instr_i[32*k +: 32]);
    end
  endgenerate

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int e = 0; e < els_p; e++) begin
        r_instr_mem[e] <= '0;
        r_pc_mem[e]    <= '0;
        r_pd_mem[e]    <= '0;
      end
    end else begin
      for (int k = 0; k < in_width_p; k++) begin
        if (w_lane_we[k]) begin
          r_instr_mem[w_lane_addr[k]] <= instr_i[32*k +: 32];
          r_pc_mem[w_lane_addr[k]]    <= w_lane_pc[k];
          r_pd_mem[w_lane_addr[k]]    <= w_lane_pd[k];
        end
      end
    end
  end

  // Pointers wrap naturally because els_p is a power of two.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (flush_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      r_wptr  <= r_wptr + c_ptr_w'(w_enq_n);
      r_rptr  <= r_rptr + c_ptr_w'(w_deq);
      r_count <= r_count + w_enq_n - c_cnt_w'(w_deq);
    end
  end

  assign v_o     = (r_count != '0);
  assign instr_o = r_instr_mem[r_rptr];
  assign pc_o    = r_pc_mem[r_rptr];
  assign pd_o    = r_pd_mem[r_rptr];
  assign count_o = r_count;

  // A packet offered during a flush is discarded, so it may ignore ready_o.
  a_yumi_needs_v: assert property (@(posedge clk_i) disable iff (!reset_n_i)
                                   yumi_i |-> v_o);
  a_v_needs_ready: assert property (@(posedge clk_i) disable iff (!reset_n_i)
                                    (v_i && !flush_i) |-> ready_o);
  a_num_range: assert property (@(posedge clk_i) disable iff (!reset_n_i)
                                v_i |-> (num_i <= c_num_w'(in_width_p)));

endmodule
`default_nettype wire
